// File: rtl/fft_frame_scaler_if.sv
// Avalon-ST complex-sample stream used on both sides of fft_frame_scaler.
//   DW : real/imag sample width (signed)
//   XW : exponent / applied-shift width (signed)
// Signals: valid, ready, error[1:0], sop, eop, re, im, expo.
// master drives the beat and reads ready; slave reads the beat and drives ready.
interface fft_frame_scaler_if #(
  parameter int DW = 12,
  parameter int XW = 6
);
  logic                 valid;
  logic                 ready;
  logic [1:0]           error;
  logic                 sop;
  logic                 eop;
  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic signed [XW-1:0] expo;

  modport master (output valid, error, sop, eop, re, im, expo, input ready);
  modport slave  (input valid, error, sop, eop, re, im, expo, output ready);
endinterface

// File: rtl/fft_frame_scaler.sv
// Post-FFT block-floating-point renormaliser.
// Each accepted frame is scaled by 2^s, s = clamp(sink.expo + cfg_offset,
// -IN_W, OUT_W) latched at sop; negative shifts round half up, results
// saturate to OUT_W bits. Framing (sop/eop/length) is checked against
// FRAME_LEN and reported on source.error[1].
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   cfg_offset  : signed exponent offset, sampled at sop
//   sink        : input stream (IN_W samples, EXP_W block exponent)
//   source      : output stream (OUT_W samples, EXP_W+1 applied shift)
//   sat_count   : saturated components in the last completed frame
//   frame_done  : pulse when an eop beat is accepted downstream
//   drop_count  : beats dropped outside a frame (saturating)
module fft_frame_scaler #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 16,
  parameter int EXP_W     = 6,
  parameter int FRAME_LEN = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [EXP_W-1:0] cfg_offset,
  fft_frame_scaler_if.slave       sink,
  fft_frame_scaler_if.master      source,
  output logic [15:0]             sat_count,
  output logic                    frame_done,
  output logic [15:0]             drop_count
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int SW    = EXP_W + 1;
  localparam int WW    = IN_W + OUT_W + 1;
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [SW-1:0] S_MIN = SW'(-IN_W);
  localparam logic signed [SW-1:0] S_MAX = SW'(OUT_W);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  // Full-precision scale: left shift, or round-half-up arithmetic right shift.
  function automatic logic signed [WW-1:0] f_scale(
    input logic signed [IN_W-1:0] x,
    input logic signed [SW-1:0]   s
  );
    logic signed [WW-1:0] xw;
    logic [SW-1:0]        sh;
    xw = WW'(x);
    if (!s[SW-1]) return xw <<< s;
    sh = -s;
    return (xw + (WW'(1) <<< (sh - SW'(1)))) >>> sh;
  endfunction

  // Returns {saturated, value}. In range iff all bits above the OUT_W sign bit
  // agree with it.
  function automatic logic [OUT_W:0] f_sat(input logic signed [WW-1:0] y);
    logic [WW-OUT_W:0] top;
    top = y[WW-1:OUT_W-1];
    if ((&top) || (~|top)) return {1'b0, y[OUT_W-1:0]};
    return {1'b1, y[WW-1], {(OUT_W-1){~y[WW-1]}}};
  endfunction

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic signed [SW-1:0]  r_s;
  logic [15:0]           r_drop;

  logic                  r_v1, r_sop1, r_eop1;
  logic [1:0]            r_err1;
  logic signed [IN_W-1:0] r_re1, r_im1;
  logic signed [SW-1:0]  r_s1;

  logic                  r_o_valid, r_o_sop, r_o_eop;
  logic [1:0]            r_o_err;
  logic signed [OUT_W-1:0] r_o_re, r_o_im;
  logic signed [SW-1:0]  r_o_exp;

  logic [15:0]           r_acc, r_sat_count;

  logic                  w_en, w_uerr, w_done;
  logic signed [SW-1:0]  w_sum, w_s_new;
  logic signed [WW-1:0]  w_y_re, w_y_im;
  logic [OUT_W:0]        w_sr_re, w_sr_im;
  logic [1:0]            w_nsat;
  logic [16:0]           w_acc_sum;

  assign w_en   = ~r_o_valid | source.ready;
  assign w_uerr = |sink.error;
  assign w_done = r_o_valid & source.ready & r_o_eop;

  always_comb begin
    w_sum   = SW'(sink.expo) + SW'(cfg_offset);
    w_s_new = w_sum;
    if (w_sum < S_MIN)      w_s_new = S_MIN;
    else if (w_sum > S_MAX) w_s_new = S_MAX;
  end

  assign w_y_re  = f_scale(r_re1, r_s1);
  assign w_y_im  = f_scale(r_im1, r_s1);
  assign w_sr_re = f_sat(w_y_re);
  assign w_sr_im = f_sat(w_y_im);
  assign w_nsat  = (w_en & r_v1) ? ({1'b0, w_sr_re[OUT_W]} + {1'b0, w_sr_im[OUT_W]}) : 2'd0;
  assign w_acc_sum = {1'b0, r_acc} + {15'd0, w_nsat};

  // Framing FSM and stage 1. Beats that are not forwarded leave r_v1 low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s     <= '0;
      r_drop  <= '0;
      r_v1    <= 1'b0;
      r_sop1  <= 1'b0;
      r_eop1  <= 1'b0;
      r_err1  <= '0;
      r_re1   <= '0;
      r_im1   <= '0;
      r_s1    <= '0;
    end else if (w_en) begin
      r_v1 <= 1'b0;
      if (sink.valid) begin
        r_sop1 <= sink.sop;
        r_eop1 <= sink.eop;
        r_re1  <= sink.re;
        r_im1  <= sink.im;
        r_s1   <= r_s;
        r_err1 <= {1'b0, w_uerr};
        if (sink.sop) begin
          // sop always (re)starts a frame; inside a frame it is a framing error.
          r_v1    <= 1'b1;
          r_s     <= w_s_new;
          r_s1    <= w_s_new;
          r_cnt   <= CNT_W'(1);
          r_err1  <= {(r_state == IN_FRAME) | sink.eop, w_uerr};
          r_state <= sink.eop ? IDLE : IN_FRAME;
        end else if (r_state == IN_FRAME) begin
          r_v1 <= 1'b1;
          if (sink.eop) begin
            r_err1  <= {r_cnt != LAST, w_uerr};
            r_state <= IDLE;
          end else if (r_cnt == LAST) begin
            r_err1  <= {1'b1, w_uerr};
            r_eop1  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (r_drop != '1) begin
          r_drop <= r_drop + 16'd1;
        end
      end
    end
  end

  // Stage 2: scaled, saturated output register. Held while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_o_valid <= 1'b0;
      r_o_sop   <= 1'b0;
      r_o_eop   <= 1'b0;
      r_o_err   <= '0;
      r_o_re    <= '0;
      r_o_im    <= '0;
      r_o_exp   <= '0;
    end else if (w_en) begin
      r_o_valid <= r_v1;
      if (r_v1) begin
        r_o_sop <= r_sop1;
        r_o_eop <= r_eop1;
        r_o_err <= r_err1;
        r_o_re  <= w_sr_re[OUT_W-1:0];
        r_o_im  <= w_sr_im[OUT_W-1:0];
        r_o_exp <= r_s1;
      end
    end
  end

  // Saturations are counted as beats enter stage 2, so when the eop beat is
  // accepted the accumulator already holds the whole frame; a beat entering
  // stage 2 on that same edge seeds the next frame's count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_sat_count <= '0;
    end else if (w_done) begin
      r_sat_count <= r_acc;
      r_acc       <= {14'd0, w_nsat};
    end else if (w_acc_sum[16]) begin
      r_acc <= '1;
    end else begin
      r_acc <= w_acc_sum[15:0];
    end
  end

  assign sink.ready    = w_en;
  assign source.valid  = r_o_valid;
  assign source.sop    = r_o_sop;
  assign source.eop    = r_o_eop;
  assign source.error  = r_o_err;
  assign source.re     = r_o_re;
  assign source.im     = r_o_im;
  assign source.expo   = r_o_exp;
  assign sat_count     = r_sat_count;
  assign frame_done    = w_done;
  assign drop_count    = r_drop;

endmodule

// File: tb/tb_fft_frame_scaler.sv
// Bench for fft_frame_scaler (IN_W=12, OUT_W=16, FRAME_LEN=8).
// Expected beats come from an integer/real reference model of the framing
// and scaling rules, queued at sink acceptance and compared at the source.
module tb_fft_frame_scaler;
  localparam int IN_W  = 12;
  localparam int OUT_W = 16;
  localparam int EXP_W = 6;
  localparam int FL    = 8;

  typedef struct {
    int re; int im; bit sop; bit eop; bit [1:0] err; int s; int t;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic signed [EXP_W-1:0] cfg_offset;
  logic [15:0] sat_count, drop_count;
  logic frame_done;

  fft_frame_scaler_if #(.DW(IN_W),  .XW(EXP_W))     sink_if ();
  fft_frame_scaler_if #(.DW(OUT_W), .XW(EXP_W + 1)) src_if ();

  fft_frame_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .cfg_offset(cfg_offset),
    .sink(sink_if), .source(src_if),
    .sat_count(sat_count), .frame_done(frame_done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  beat_t q[$];
  int    sat_q[$];
  bit m_in;
  int m_idx, m_s, m_acc, m_drop;
  bit rand_rdy, lat_chk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  function automatic int ref_scale(input int x, input int s, output bit sat);
    real r;
    if (s >= 0) r = x * (2.0 ** s);
    else        r = $floor((x + 2.0 ** (-s - 1)) / (2.0 ** (-s)));
    sat = 1'b0;
    if (r > 32767.0)  begin sat = 1'b1; return 32767;  end
    if (r < -32768.0) begin sat = 1'b1; return -32768; end
    return int'(r);
  endfunction

  task automatic model_accept(input bit sop, input bit eop, input int re, input int im,
                              input int ex, input int off, input bit [1:0] err, input int t);
    beat_t e;
    bit sr, si;
    int sum;
    if (!sop && !m_in) begin
      if (m_drop < 65535) m_drop++;
      return;
    end
    e.sop = sop; e.eop = eop; e.err = {1'b0, |err}; e.t = t;
    if (sop) begin
      e.err[1] = m_in || eop;
      sum = ex + off;
      m_s = (sum < -IN_W) ? -IN_W : (sum > OUT_W) ? OUT_W : sum;
      m_idx = 0;
      m_in = !eop;
    end else begin
      m_idx++;
      if (eop) begin
        e.err[1] = (m_idx != FL - 1);
        m_in = 1'b0;
      end else if (m_idx == FL - 1) begin
        e.eop = 1'b1; e.err[1] = 1'b1; m_in = 1'b0;
      end
    end
    e.s  = m_s;
    e.re = ref_scale(re, m_s, sr);
    e.im = ref_scale(im, m_s, si);
    m_acc = m_acc + int'(sr) + int'(si);
    if (m_acc > 65535) m_acc = 65535;
    if (e.eop) begin sat_q.push_back(m_acc); m_acc = 0; end
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    src_if.ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_beat(input bit sop, input bit eop, input int re, input int im,
                           input int ex, input bit [1:0] err);
    int waited = 0;
    bit done = 1'b0;
    sink_if.valid = 1'b1; sink_if.sop = sop; sink_if.eop = eop;
    sink_if.re = IN_W'(re); sink_if.im = IN_W'(im);
    sink_if.expo = EXP_W'(ex); sink_if.error = err;
    while (!done && waited < 1000) begin
      @(negedge clk);
      if (sink_if.ready) begin
        model_accept(sop, eop, re, im, ex, int'(cfg_offset), err, cyc);
        done = 1'b1;
      end
      tick();
      waited++;
    end
    sink_if.valid = 1'b0;
    check("sink_accept_timeout", done, 1);
  endtask

  function automatic int rnd(input int d);
    return int'($urandom_range(0, 2 * d)) - d;
  endfunction

  task automatic send_frame(input int n, input bit with_eop, input int ex, input int off,
                            input int re0, input int im0, input int re1, input int im1,
                            input int dmax);
    int re, im;
    cfg_offset = EXP_W'(off);
    for (int i = 0; i < n; i++) begin
      re = (i == 0) ? re0 : (i == 1) ? re1 : rnd(dmax);
      im = (i == 0) ? im0 : (i == 1) ? im1 : rnd(dmax);
      send_beat(i == 0, with_eop && (i == n - 1), re, im, ex, 2'b00);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin tick(); n++; end
    check("drain_timeout", q.size() == 0, 1);
    repeat (3) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, src_if.valid, 0);
    check({tag, "_real"},  src_if.re, 0);
    check({tag, "_imag"},  src_if.im, 0);
    check({tag, "_sop"},   src_if.sop, 0);
    check({tag, "_eop"},   src_if.eop, 0);
    check({tag, "_error"}, src_if.error, 0);
    check({tag, "_exp"},   src_if.expo, 0);
    check({tag, "_sat"},   sat_count, 0);
    check({tag, "_drop"},  drop_count, 0);
    check({tag, "_done"},  frame_done, 0);
  endtask

  task automatic model_reset();
    q.delete(); sat_q.delete();
    m_in = 1'b0; m_idx = 0; m_s = 0; m_acc = 0; m_drop = 0;
  endtask

  // Output monitor
  bit stalled = 1'b0;
  bit pend_sat = 1'b0;
  int exp_sat;
  logic [63:0] prev_data, prev_ctrl;
  always @(negedge clk) begin
    beat_t e;
    if (reset !== 1'b0) begin
      stalled = 1'b0;
      pend_sat = 1'b0;
    end else begin
      if (pend_sat) begin
        pend_sat = 1'b0;
        check("sat_count", sat_count, exp_sat);
      end
      if (stalled) begin
        check("stall_data", {src_if.re, src_if.im}, prev_data);
        check("stall_ctrl", {src_if.valid, src_if.sop, src_if.eop, src_if.error, src_if.expo}, prev_ctrl);
      end
      if (src_if.valid && src_if.ready) begin
        check("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("real",  src_if.re,    e.re);
          check("imag",  src_if.im,    e.im);
          check("sop",   src_if.sop,   e.sop);
          check("eop",   src_if.eop,   e.eop);
          check("error", src_if.error, e.err);
          check("exp",   src_if.expo,  e.s);
          check("frame_done", frame_done, e.eop);
          if (lat_chk) check("latency", cyc, e.t + 2);
          if (e.eop && sat_q.size() != 0) begin
            exp_sat = sat_q.pop_front();
            pend_sat = 1'b1;
          end
        end
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
      stalled   = src_if.valid && !src_if.ready;
      prev_data = {src_if.re, src_if.im};
      prev_ctrl = {src_if.valid, src_if.sop, src_if.eop, src_if.error, src_if.expo};
    end
  end

  initial begin
    int ex, off;
    bit [1:0] err;
    reset = 1'b0;
    sink_if.valid = 1'b0; sink_if.sop = 1'b0; sink_if.eop = 1'b0; sink_if.error = '0;
    sink_if.re = '0; sink_if.im = '0; sink_if.expo = '0;
    src_if.ready = 1'b1; cfg_offset = '0;
    rand_rdy = 1'b0; lat_chk = 1'b1;
    model_reset();

    // Reset state
    #1 reset = 1'b1;
    #2 check_zero("reset");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Scaling and rounding, exact two-cycle latency
    send_frame(8, 1, -2, 0, 100, -100, 7, -7, 2047);
    send_frame(8, 1, -1, 0, 3, -3, -3, 3, 2047);
    send_frame(8, 1, 1, -3, 5, -5, 6, -6, 2047);
    drain();

    // Saturation boundaries
    send_frame(8, 1, 4, 0, 2047, -2048, -2048, 2047, 2047);
    drain();
    check("sat_count_exp4", sat_count, 0);
    send_frame(8, 1, 5, 0, 2047, -2048, 1023, -1023, 1023);
    drain();
    check("sat_count_exp5", sat_count, 2);

    // Shift clamping at both ends
    send_frame(8, 1, 31, 0, 0, 1, -1, 0, 2047);
    send_frame(8, 1, -32, -5, 2047, -2048, 2048 - 1, -2047, 2047);
    drain();

    // Framing: clean, early eop, missing eop with drops
    send_frame(8, 1, 0, 0, 1, 2, 3, 4, 2047);
    send_frame(5, 1, 0, 0, 1, 2, 3, 4, 2047);
    send_frame(10, 0, 0, 0, 1, 2, 3, 4, 2047);
    drain();
    check("drop_count", drop_count, 2);

    // sop+eop single beat, then restart mid-frame
    send_beat(1, 1, 100, -100, 0, 2'b00);
    send_frame(3, 0, -3, 0, 9, -9, 10, -10, 2047);
    send_frame(8, 1, -3, 1, 9, -9, 10, -10, 2047);
    drain();

    // Random data, exponents, errors and backpressure; offset wiggles mid-frame
    rand_rdy = 1'b1;
    lat_chk  = 1'b0;
    for (int f = 0; f < 4; f++) begin
      ex  = int'($urandom_range(0, 14)) - 8;
      off = int'($urandom_range(0, 4)) - 2;
      cfg_offset = EXP_W'(off);
      for (int i = 0; i < FL; i++) begin
        err = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send_beat(i == 0, i == FL - 1, rnd(2047), rnd(2047), ex, err);
        cfg_offset = EXP_W'(rnd(8));
      end
    end
    drain();
    rand_rdy = 1'b0;
    lat_chk  = 1'b1;

    // Reset mid-frame
    cfg_offset = '0;
    send_beat(1, 0, 11, -11, -1, 2'b00);
    send_beat(0, 0, 12, -12, -1, 2'b00);
    send_beat(0, 0, 13, -13, -1, 2'b00);
    reset = 1'b1;
    #1 check_zero("midreset");
    model_reset();
    tick();
    check_zero("midreset_edge");
    tick();
    reset = 1'b0;
    tick();
    send_frame(8, 1, -1, 0, 3, -3, 5, -5, 2047);
    drain();
    check("drop_after_reset", drop_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
